mdu_sequencer: RTL and testbench

//  Sequences the multiply/divide unit for the E stage of the 5-stage pipeline: latches operands on start,

---
 rtl/mdu_pkg.sv | 31 +++
 rtl/mdu_arith.sv | 67 ++++++
 rtl/mdu_sequencer.sv | 145 ++++++++++++++
 tb/tb_mdu_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - md opcode encodings (3-bit)
//   - sequencer FSM state type
//   - default latency / counter-width constants
// The optional multiply-accumulate opcodes (MADD/MADDU/MSUB/MSUBU) only take effect when the
// MDU_MADD_EN macro is defined; the encodings are always reserved here.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MADD  = 3'd4;
    localparam logic [2:0] MDU_MADDU = 3'd5;
    localparam logic [2:0] MDU_MSUB  = 3'd6;
    localparam logic [2:0] MDU_MSUBU = 3'd7;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;
    localparam int unsigned CNT_W_DEF       = 5;

    typedef enum logic {
        StIdle,
        StRun
    } mdu_state_e;

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit HI/LO result for the latched md operation.
// Ports:
//   op_i    latched md opcode
//   a_i     latched rs operand
//   b_i     latched rt operand
//   hilo_i  current {HI, LO} (accumulate source)
//   res_o   {HI, LO} to commit
//   div0_o  divide op with zero divisor; caller must leave HI/LO unchanged
// Config: MDU_MADD_EN enables the multiply-accumulate/subtract results.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [63:0] hilo_i,
    output logic [63:0] res_o,
    output logic        div0_o
);

    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;
    logic        [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               sgn;
    logic        [31:0] dvd;
    logic        [31:0] dvs;
    logic        [31:0] uq;
    logic        [31:0] ur;
    logic        [31:0] q;
    logic        [31:0] r;

    assign a_ext  = {{32{a_i[31]}}, a_i};
    assign b_ext  = {{32{b_i[31]}}, b_i};
    assign prod_s = a_ext * b_ext;
    assign prod_u = {32'd0, a_i} * {32'd0, b_i};

    // One unsigned divider shared by div/divu: signed divide works on magnitudes and fixes
    // signs afterwards, which also makes 0x80000000 / -1 fall out as LO=0x80000000, HI=0.
    assign sgn    = (op_i == MDU_DIV);
    assign dvd    = (sgn && a_i[31]) ? (~a_i + 32'd1) : a_i;
    assign dvs    = (b_i == 32'd0) ? 32'd1 :
                    ((sgn && b_i[31]) ? (~b_i + 32'd1) : b_i);
    assign uq     = dvd / dvs;
    assign ur     = dvd % dvs;
    assign q      = (sgn && (a_i[31] ^ b_i[31])) ? (~uq + 32'd1) : uq;
    assign r      = (sgn && a_i[31]) ? (~ur + 32'd1) : ur;
    assign div0_o = is_div_op(op_i) && (b_i == 32'd0);

    always_comb begin
        res_o = hilo_i;
        case (op_i)
            MDU_MULT:  res_o = prod_s;
            MDU_MULTU: res_o = prod_u;
            MDU_DIV,
            MDU_DIVU:  res_o = {r, q};
`ifdef MDU_MADD_EN
            MDU_MADD:  res_o = hilo_i + prod_s;
            MDU_MADDU: res_o = hilo_i + prod_u;
            MDU_MSUB:  res_o = hilo_i - prod_s;
            MDU_MSUBU: res_o = hilo_i - prod_u;
`endif
            default:   res_o = hilo_i;
        endcase
    end

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: E-stage multiply/divide sequencer.
// Latches op/operands on start, counts the op latency, reports busy/remaining cycles to hazard
// logic and commits HI/LO at completion. Handles mthi/mtlo and CP0 cancel.
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   start, op         md op issue pulse and opcode (mdu_pkg encoding)
//   rs_val, rt_val    forwarded operands, sampled only on an accepted start
//   hi_we, lo_we      mthi/mtlo strobes (hi_we wins if both), data on wdata
//   cancel            squashes a starting or in-flight op and any mthi/mtlo
//   busy, remain      op in flight / cycles left before commit (0 when idle)
//   done              one-cycle pulse following the commit edge
//   hi, lo            HI/LO registers
// Config: define MDU_MADD_EN to accept MADD/MADDU/MSUB/MSUBU; otherwise those opcodes are no-ops.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [31:0]      wdata,
    input  logic             cancel,
    output logic             busy,
    output logic [CNT_W-1:0] remain,
    output logic             done,
    output logic [31:0]      hi,
    output logic [31:0]      lo
);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic             done_q, done_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [2:0]       op_q, op_d;
    logic [31:0]      rs_q, rs_d;
    logic [31:0]      rt_q, rt_d;

    logic             op_ok;
    logic [CNT_W-1:0] latency;
    logic [63:0]      res;
    logic             div0;

`ifdef MDU_MADD_EN
    assign op_ok = 1'b1;
`else
    assign op_ok = ~op[2];
`endif

    assign latency = is_div_op(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    mdu_arith u_arith (
        .op_i   (op_q),
        .a_i    (rs_q),
        .b_i    (rt_q),
        .hilo_i ({hi_q, lo_q}),
        .res_o  (res),
        .div0_o (div0)
    );

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        op_d     = op_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        case (state_q)
            StIdle: begin
                if (start && !cancel && op_ok) begin
                    state_d  = StRun;
                    remain_d = latency;
                    op_d     = op;
                    rs_d     = rs_val;
                    rt_d     = rt_val;
                end else if (!cancel) begin
                    // A rejected start (no-op opcode) does not block mthi/mtlo.
                    if (hi_we) begin
                        hi_d = wdata;
                    end else if (lo_we) begin
                        lo_d = wdata;
                    end
                end
            end
            StRun: begin
                if (cancel) begin
                    state_d  = StIdle;
                    remain_d = '0;
                end else if (remain_q == CNT_W'(1)) begin
                    state_d  = StIdle;
                    remain_d = '0;
                    done_d   = 1'b1;
                    if (!div0) begin
                        {hi_d, lo_d} = res;
                    end
                end else begin
                    remain_d = remain_q - CNT_W'(1);
                end
            end
            default: begin
                state_d  = StIdle;
                remain_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            remain_q <= '0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            op_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            op_q     <= op_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
        end
    end

    assign busy   = (state_q == StRun);
    assign remain = remain_q;
    assign done   = done_q;
    assign hi     = hi_q;
    assign lo     = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: transaction-level model plus directed vectors with literal expectations.
module tb_mdu_sequencer;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;
    localparam int unsigned CW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [31:0]   rs_val = 32'd0;
    logic [31:0]   rt_val = 32'd0;
    logic          hi_we = 1'b0;
    logic          lo_we = 1'b0;
    logic [31:0]   wdata = 32'd0;
    logic          cancel = 1'b0;
    logic          busy;
    logic [CW-1:0] remain;
    logic          done;
    logic [31:0]   hi;
    logic [31:0]   lo;

    always #5 clk = ~clk;

    mdu_sequencer #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC),
        .CNT_W       (CW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .cancel (cancel),
        .busy   (busy),
        .remain (remain),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int          m_left = 0;      // cycles until commit, 0 when idle
    logic [31:0] m_hi = 0, m_lo = 0;
    logic        m_done = 0;
    logic [2:0]  m_op = 0;
    logic [31:0] m_a = 0, m_b = 0;

    function automatic bit accepted(input logic [2:0] o);
`ifdef MDU_MADD_EN
        return 1'b1;
`else
        return o < 3'd4;
`endif
    endfunction

    function automatic logic [63:0] model_res(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] hl);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint ua = {32'd0, a};
        longint ub = {32'd0, b};
        longint q, r;
        case (o)
            3'd0: return 64'(sa * sb);
            3'd1: return 64'(ua * ub);
            3'd2: begin
                if (b == 0) return hl;
                q = sa / sb; r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 0) return hl;
                q = ua / ub; r = ua % ub;
                return {r[31:0], q[31:0]};
            end
            3'd4: return hl + 64'(sa * sb);
            3'd5: return hl + 64'(ua * ub);
            3'd6: return hl - 64'(sa * sb);
            default: return hl - 64'(ua * ub);
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left = 0; m_hi = 0; m_lo = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (m_left > 0) begin
                if (cancel) m_left = 0;
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        {m_hi, m_lo} = model_res(m_op, m_a, m_b, {m_hi, m_lo});
                        m_done = 1;
                    end
                end
            end else if (!cancel) begin
                if (start && accepted(op)) begin
                    m_left = (op == 3'd2 || op == 3'd3) ? DC : MC;
                    m_op = op; m_a = rs_val; m_b = rt_val;
                end else if (hi_we) m_hi = wdata;
                else if (lo_we) m_lo = wdata;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            chk("cyc busy",   64'(busy),   64'(m_left > 0));
            chk("cyc remain", 64'(remain), 64'(m_left));
            chk("cyc done",   64'(done),   64'(m_done));
            chk("cyc hi",     64'(hi),     64'(m_hi));
            chk("cyc lo",     64'(lo),     64'(m_lo));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        cyc();
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        // Operands must have been latched; scramble the live inputs.
        rs_val = 32'hDEADBEEF; rt_val = 32'h0;
    endtask

    task automatic wait_idle(output int nb);
        nb = 0;
        while (busy && nb < 50) begin
            nb++;
            cyc();
        end
    endtask

    int nb;

    initial begin
        cyc(); cyc();
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset remain", 64'(remain), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        reset = 1'b0;
        cmp_en = 1'b1;
        cyc();

        // mult -1 * 2
        issue(3'd0, 32'hFFFFFFFF, 32'd2);
        chk("mult busy", 64'(busy), 64'd1);
        chk("mult remain", 64'(remain), 64'd5);
        wait_idle(nb);
        chk("mult busy cycles", 64'(nb), 64'd5);
        chk("mult done", 64'(done), 64'd1);
        chk("mult hi", 64'(hi), 64'hFFFFFFFF);
        chk("mult lo", 64'(lo), 64'hFFFFFFFE);
        cyc();
        chk("mult done pulse", 64'(done), 64'd0);

        // multu same operands
        issue(3'd1, 32'hFFFFFFFF, 32'd2);
        wait_idle(nb);
        chk("multu hi", 64'(hi), 64'd1);
        chk("multu lo", 64'(lo), 64'hFFFFFFFE);

        // div -7 / 2
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        wait_idle(nb);
        chk("div busy cycles", 64'(nb), 64'd10);
        chk("div lo", 64'(lo), 64'hFFFFFFFD);
        chk("div hi", 64'(hi), 64'hFFFFFFFF);

        // divu 7 / 0
        issue(3'd3, 32'd7, 32'd0);
        wait_idle(nb);
        chk("divu0 busy cycles", 64'(nb), 64'd10);
        chk("divu0 done", 64'(done), 64'd1);
        chk("divu0 hi", 64'(hi), 64'hFFFFFFFF);
        chk("divu0 lo", 64'(lo), 64'hFFFFFFFD);

        // overflow divide
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(nb);
        chk("divovf lo", 64'(lo), 64'h80000000);
        chk("divovf hi", 64'(hi), 64'd0);

        // cancel at remain=4
        issue(3'd2, 32'd100, 32'd7);
        repeat (6) cyc();
        chk("cancel remain", 64'(remain), 64'd4);
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
        chk("cancel busy", 64'(busy), 64'd0);
        chk("cancel done", 64'(done), 64'd0);
        chk("cancel hi", 64'(hi), 64'd0);
        chk("cancel lo", 64'(lo), 64'h80000000);
        cyc();
        chk("cancel no done", 64'(done), 64'd0);

        // start & cancel together
        op = 3'd0; rs_val = 32'd3; rt_val = 32'd3; start = 1'b1; cancel = 1'b1;
        cyc();
        start = 1'b0; cancel = 1'b0;
        chk("startcancel busy", 64'(busy), 64'd0);

        // mthi / mtlo in idle
        hi_we = 1'b1; wdata = 32'h1234;
        cyc();
        hi_we = 1'b0;
        chk("mthi", 64'(hi), 64'h1234);
        lo_we = 1'b1; wdata = 32'h5678;
        cyc();
        lo_we = 1'b0;
        chk("mtlo", 64'(lo), 64'h5678);

        // mtlo during RUN ignored
        issue(3'd0, 32'd3, 32'd4);
        lo_we = 1'b1; wdata = 32'hFFFF;
        cyc();
        lo_we = 1'b0;
        chk("mtlo in run", 64'(lo), 64'h5678);
        wait_idle(nb);
        chk("mult34 lo", 64'(lo), 64'd12);
        chk("mult34 hi", 64'(hi), 64'd0);

        // both strobes: hi wins
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAAAA;
        cyc();
        hi_we = 1'b0; lo_we = 1'b0;
        chk("both we hi", 64'(hi), 64'hAAAA);
        chk("both we lo", 64'(lo), 64'd12);

        // start has priority over mthi
        hi_we = 1'b1; wdata = 32'hBBBB;
        issue(3'd0, 32'd2, 32'd3);
        chk("start prio hi", 64'(hi), 64'hAAAA);
        // start while RUN ignored
        op = 3'd2; rs_val = 32'd100; rt_val = 32'd3; start = 1'b1;
        cyc();
        start = 1'b0;
        wait_idle(nb);
        chk("run start ign lo", 64'(lo), 64'd6);
        chk("run start ign hi", 64'(hi), 64'd0);

        // multiply-accumulate
        hi_we = 1'b1; wdata = 32'd0;
        cyc();
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'hFFFFFFFF;
        cyc();
        lo_we = 1'b0;
        issue(3'd4, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        wait_idle(nb);
        chk("madd busy cycles", 64'(nb), 64'd5);
        chk("madd hi", 64'(hi), 64'd1);
        chk("madd lo", 64'(lo), 64'd0);
`else
        chk("madd noop busy", 64'(busy), 64'd0);
        cyc();
        chk("madd noop done", 64'(done), 64'd0);
        chk("madd noop lo", 64'(lo), 64'hFFFFFFFF);
`endif

        // reset mid-RUN
        issue(3'd2, 32'd50, 32'd3);
        repeat (4) cyc();
        chk("rst run remain", 64'(remain), 64'd6);
        reset = 1'b1;
        #1;
        chk("rst run busy", 64'(busy), 64'd0);
        chk("rst run remain0", 64'(remain), 64'd0);
        chk("rst run done", 64'(done), 64'd0);
        chk("rst run hi", 64'(hi), 64'd0);
        chk("rst run lo", 64'(lo), 64'd0);
        cyc();
        reset = 1'b0;
        cyc();
        chk("post rst busy", 64'(busy), 64'd0);
        chk("post rst done", 64'(done), 64'd0);
        cyc();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
